// File: rtl/pri_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pri_arb_pkg
//  Description : Shared types and helpers for the pri_arbiter_rr block.
//                - state_t         : arbiter FSM state encoding (IDLE, GRANT)
//                - hold_cnt_width  : hold-counter width for a given HOLD_MAX
//  Revision    : 1.0  initial release
// ============================================================================
package pri_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // The counter only needs to reach HOLD_MAX-1, so clog2(HOLD_MAX) bits are
    // enough. HOLD_MAX=1 would give zero bits, so one bit is the floor.
    function automatic int hold_cnt_width(input int hold_max);
        return (hold_max <= 1) ? 1 : $clog2(hold_max);
    endfunction

endpackage : pri_arb_pkg
`default_nettype wire

// File: rtl/pri_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : pri_arbiter_rr_if
//  Description : Request/grant bundle between N requesters and the arbiter.
//  Signals     : req[N]        requester i wants the resource
//                done          current owner has finished
//                gnt[N]        one-hot registered grant
//                gnt_idx[IDX_W] binary index of the grant (0 when idle)
//                gnt_valid     a grant is being held
//                timeout       pulse after a HOLD_MAX forced release
//  Modports    : master (requester side), slave (arbiter side)
//  Revision    : 1.0  initial release
// ============================================================================
interface pri_arbiter_rr_if #(
    parameter int N = 8
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

endinterface : pri_arbiter_rr_if
`default_nettype wire

// File: rtl/pri_encoder_n.sv
`default_nettype none
// ============================================================================
//  Module      : pri_encoder_n
//  Description : Combinational N-to-IDX_W priority encoder; the highest set
//                input bit wins. valid is high when any input bit is set.
//  Ports       : vec_in[N]   input vector
//                idx[IDX_W]  index of highest set bit (0 when none set)
//                valid       any bit of vec_in set
//  Revision    : 1.0  initial release
// ============================================================================
module pri_encoder_n #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  wire logic [N-1:0]     vec_in,
    output logic      [IDX_W-1:0] idx,
    output logic                  valid
);

    always_comb begin
        idx   = '0;
        valid = |vec_in;
        // Ascending scan: the last (highest) set bit overwrites earlier ones.
        for (int i = 0; i < N; i++) begin
            if (vec_in[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule : pri_encoder_n
`default_nettype wire

// File: rtl/pri_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : pri_arbiter_rr
//  Description : N-requester arbiter with a registered one-hot grant. A grant
//                is held until done, the owner drops its request, or the
//                HOLD_MAX cycle limit is reached; one idle cycle always
//                separates consecutive grants.
//                Default policy: fixed priority, highest index wins.
//                Define PRI_ARB_RR_EN to build the round-robin policy.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                bus    pri_arbiter_rr_if.slave (req, done, gnt, gnt_idx,
//                       gnt_valid, timeout)
//  Revision    : 1.0  initial release
// ============================================================================
module pri_arbiter_rr
    import pri_arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int HOLD_MAX = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pri_arbiter_rr_if.slave   bus
);

    localparam int IDX_W    = $clog2(N);
    localparam int c_hold_w = hold_cnt_width(HOLD_MAX);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_MAX - 1);

    state_t              r_state,   w_state_nxt;
    logic [N-1:0]        r_gnt,     w_gnt_nxt;
    logic [IDX_W-1:0]    r_idx,     w_idx_nxt;
    logic                r_valid,   w_valid_nxt;
    logic                r_timeout, w_timeout_nxt;
    logic [c_hold_w-1:0] r_hold,    w_hold_nxt;

    logic [N-1:0]        w_enc_in;
    logic [IDX_W-1:0]    w_enc_idx;
    logic                w_any;
    logic [IDX_W-1:0]    w_win_idx;
    logic [N-1:0]        w_win_onehot;

    logic                w_drop;
    logic                w_lim;

`ifdef PRI_ARB_RR_EN
    localparam logic [IDX_W:0] c_n = (IDX_W+1)'(N);

    logic [IDX_W-1:0]    r_ptr;
    // Set from reset until the first grant: the first search starts at N-1.
    logic                r_fresh;
    logic [IDX_W-1:0]    w_off;
    logic [2*N-1:0]      w_dbl;
    logic [IDX_W:0]      w_sum;

    // Rotating by the last winner k puts index k-1 at the top of the encoder
    // and k itself at the bottom, giving descending-with-wrap order.
    assign w_off    = r_fresh ? '0 : r_ptr;
    assign w_dbl    = {bus.req, bus.req};
    assign w_enc_in = w_dbl[w_off +: N];
    assign w_sum    = {1'b0, w_enc_idx} + {1'b0, w_off};
    assign w_win_idx = (w_sum >= c_n) ? IDX_W'(w_sum - c_n) : IDX_W'(w_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= IDX_W'(N - 1);
            r_fresh <= 1'b1;
        end else if ((r_state == IDLE) && w_any) begin
            r_ptr   <= w_win_idx;
            r_fresh <= 1'b0;
        end
    end
`else
    assign w_enc_in  = bus.req;
    assign w_win_idx = w_enc_idx;
`endif

    pri_encoder_n #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec_in (w_enc_in),
        .idx    (w_enc_idx),
        .valid  (w_any)
    );

    always_comb begin
        w_win_onehot            = '0;
        w_win_onehot[w_win_idx] = 1'b1;
    end

    assign w_drop = ~bus.req[r_idx];
    assign w_lim  = (r_hold == c_hold_last);

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_idx_nxt     = r_idx;
        w_valid_nxt   = r_valid;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_win_onehot;
                    w_idx_nxt   = w_win_idx;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (bus.done || w_drop || w_lim) begin
                    w_state_nxt   = IDLE;
                    w_gnt_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_valid_nxt   = 1'b0;
                    w_hold_nxt    = '0;
                    // Only a release caused purely by the limit is a timeout.
                    w_timeout_nxt = w_lim && !bus.done && !w_drop;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_idx     <= w_idx_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
            r_hold    <= w_hold_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_idx   = r_idx;
    assign bus.gnt_valid = r_valid;
    assign bus.timeout   = r_timeout;

endmodule : pri_arbiter_rr
`default_nettype wire

// File: tb/tb_pri_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pri_arbiter_rr
//  Description : Directed self-checking bench for pri_arbiter_rr with N=8,
//                HOLD_MAX=4. Expected values follow the fixed-priority policy
//                by default and the round-robin policy when PRI_ARB_RR_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pri_arbiter_rr;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    pri_arbiter_rr_if #(.N(8)) bus ();

    pri_arbiter_rr #(
        .N        (8),
        .HOLD_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse placed between edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [2:0] rr_seq [9];
    logic [2:0] exp_idx;

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.req  = 8'hFF;
        bus.done = 1'b0;

`ifdef PRI_ARB_RR_EN
        rr_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`else
        rr_seq = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif

        // Reset with all requests pending, then first grant.
        tick();
        tick();
        chk("rst_gnt",       32'(bus.gnt),       32'h00);
        chk("rst_idx",       32'(bus.gnt_idx),   32'd0);
        chk("rst_valid",     32'(bus.gnt_valid), 32'd0);
        chk("rst_timeout",   32'(bus.timeout),   32'd0);
        rst_n = 1'b1;
        tick();
        chk("first_gnt",     32'(bus.gnt),       32'h80);
        chk("first_idx",     32'(bus.gnt_idx),   32'd7);
        chk("first_valid",   32'(bus.gnt_valid), 32'd1);

        // Completion via done, one bubble, then re-grant.
        pulse_reset();
        bus.req = 8'b0000_1010;
        tick();
        chk("done_idx",      32'(bus.gnt_idx),   32'd3);
        chk("done_gnt",      32'(bus.gnt),       32'h08);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("done_bubble",   32'(bus.gnt),       32'h00);
        chk("done_bub_vld",  32'(bus.gnt_valid), 32'd0);
        tick();
`ifdef PRI_ARB_RR_EN
        exp_idx = 3'd1;
`else
        exp_idx = 3'd3;
`endif
        chk("done_regrant",  32'(bus.gnt_idx),   32'(exp_idx));

        // Owner drops its request.
        pulse_reset();
        bus.req = 8'b0011_0000;
        tick();
        chk("drop_idx",      32'(bus.gnt_idx),   32'd5);
        bus.req = 8'b0001_0000;
        tick();
        chk("drop_bubble",   32'(bus.gnt),       32'h00);
        chk("drop_tmo",      32'(bus.timeout),   32'd0);
        tick();
        chk("drop_next",     32'(bus.gnt_idx),   32'd4);
        chk("drop_next_gnt", 32'(bus.gnt),       32'h10);

        // Timeout: index 6 held exactly 4 cycles, then one-cycle timeout.
        pulse_reset();
        bus.req = 8'b0100_0100;
        tick();
        chk("tmo_c1",        32'(bus.gnt_idx),   32'd6);
        tick();
        chk("tmo_c2",        32'(bus.gnt_valid), 32'd1);
        tick();
        chk("tmo_c3",        32'(bus.gnt_valid), 32'd1);
        tick();
        chk("tmo_c4",        32'(bus.gnt),       32'h40);
        chk("tmo_c4_pulse",  32'(bus.timeout),   32'd0);
        tick();
        chk("tmo_release",   32'(bus.gnt_valid), 32'd0);
        chk("tmo_pulse",     32'(bus.timeout),   32'd1);
        tick();
        chk("tmo_pulse_end", 32'(bus.timeout),   32'd0);
`ifdef PRI_ARB_RR_EN
        exp_idx = 3'd2;
`else
        exp_idx = 3'd6;
`endif
        chk("tmo_next_idx",  32'(bus.gnt_idx),   32'(exp_idx));
        tick();
        tick();
        tick();
        // Fourth grant cycle: done coincides with the limit.
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("tmo_done_rel",  32'(bus.gnt_valid), 32'd0);
        chk("tmo_done_none", 32'(bus.timeout),   32'd0);

        // Index sequence under full load with done on every grant.
        pulse_reset();
        bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("seq_%0d", i), 32'(bus.gnt_idx), 32'(rr_seq[i]));
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            chk($sformatf("seq_gap_%0d", i), 32'(bus.gnt_valid), 32'd0);
        end

        // Asynchronous reset in the middle of a grant.
        pulse_reset();
        bus.req = 8'b0010_0100;
        tick();
        chk("arst_pre_idx",  32'(bus.gnt_idx),   32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt",      32'(bus.gnt),       32'h00);
        chk("arst_valid",    32'(bus.gnt_valid), 32'd0);
        chk("arst_timeout",  32'(bus.timeout),   32'd0);
        chk("arst_idx",      32'(bus.gnt_idx),   32'd0);
        bus.req = 8'b1010_0000;
        #1;
        rst_n = 1'b1;
        tick();
        chk("arst_regrant",  32'(bus.gnt_idx),   32'd7);
        chk("arst_regnt_oh", 32'(bus.gnt),       32'h80);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_pri_arbiter_rr
`default_nettype wire
